// File: rtl/cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// cfg_loader_pkg
// Shared types and helpers for the configuration-chain loader.
//   state_t    : loader FSM states (IDLE, LOAD, SHIFT, DONE)
//   CRC8_POLY  : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   CRC8_INIT  : CRC-8 register start value
//   crc8_bit() : advance a CRC-8 register by one serial bit
// ---------------------------------------------------------------------------
package cfg_loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [BYTE_W-1:0] CRC8_POLY = 8'h07;
    localparam logic [BYTE_W-1:0] CRC8_INIT = 8'h00;

    // MSB-first serial CRC step: feedback is the outgoing MSB xor the new bit
    function automatic logic [BYTE_W-1:0] crc8_bit(input logic [BYTE_W-1:0] crc,
                                                   input logic              din);
        logic fb;
        fb = crc[BYTE_W-1] ^ din;
        return {crc[BYTE_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : {BYTE_W{1'b0}});
    endfunction

endpackage

// File: rtl/cfg_crc8_serial.sv
// ---------------------------------------------------------------------------
// cfg_crc8_serial
// Bit-serial CRC-8 register with synchronous clear and enable.
// Only compiled when CFG_CRC_EN is defined (the loader instantiates it
// only in that build).
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, loads CRC8_INIT
//   clr   : synchronous clear to CRC8_INIT (wins over en)
//   en    : absorb din this cycle
//   din   : serial data bit
//   crc   : current CRC value
// ---------------------------------------------------------------------------
`ifdef CFG_CRC_EN
module cfg_crc8_serial
    import cfg_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [BYTE_W-1:0] crc
);

    // CRC register
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            crc <= CRC8_INIT;
        end else if (en) begin
            crc <= crc8_bit(crc, din);
        end
    end

endmodule
`endif

// File: rtl/fpga_cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// fpga_cfg_chain_loader
// Transmitter end of the fabric configuration chain. Accepts the bitstream
// as bytes over valid/ready and shifts it MSB first into the ccff chain,
// one bit per clk, for exactly CHAIN_LEN bits, then flags completion.
// Optional build macro CFG_CRC_EN: a CRC-8 over every shifted bit is checked
// against one trailer byte accepted after the last chain bit.
// Ports:
//   clk           : single clock
//   reset         : synchronous active-high reset
//   start         : begin a load (honoured in IDLE or DONE only)
//   in_data       : bitstream byte, MSB shifted first
//   in_valid      : in_data valid
//   in_ready      : byte accepted this cycle when in_valid is high
//   ccff_head     : serial data into the chain head
//   prog_shift_en : chain advances on clk edges where high
//   busy          : load in progress (LOAD or SHIFT)
//   done          : chain fully programmed
//   crc_err       : trailer mismatch (constant 0 without CFG_CRC_EN)
// ---------------------------------------------------------------------------
module fpga_cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              prog_shift_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int unsigned      CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
`ifdef CFG_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [BIT_IDX_W-1:0]   bit_q, bit_d;
    // Bits 6..0 of the byte shift register; bit 7 is the ccff_head register
    logic [BYTE_W-2:0]      rest_q, rest_d;

    logic in_ready_d, ccff_head_d, prog_shift_en_d, busy_d, done_d;
    logic start_ok, accept, trailer, last_chain, byte_end;

    // Event decode shared by the FSM and datapath
    always_comb begin
        cnt_inc    = cnt_q + CNT_W'(1);
        start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
        accept     = (state_q == LOAD) && in_valid;
        // With the CRC trailer, a LOAD after a full chain takes the check byte
        trailer    = CRC_ON && (cnt_q == LAST_CNT);
        last_chain = (cnt_inc == LAST_CNT);
        byte_end   = (bit_q == BIT_IDX_W'(BYTE_W - 1)) || last_chain;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (accept) state_d = trailer ? DONE : SHIFT;
            SHIFT:   if (byte_end) state_d = (last_chain && !CRC_ON) ? DONE : LOAD;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; outputs are registered off state_d so
    // they line up with the state they describe
    always_comb begin
        in_ready_d      = (state_d == LOAD);
        busy_d          = (state_d == LOAD) || (state_d == SHIFT);
        done_d          = (state_d == DONE);
        prog_shift_en_d = (state_d == SHIFT);
        ccff_head_d     = ccff_head;
        rest_d          = rest_q;
        bit_d           = bit_q;
        cnt_d           = cnt_q;

        if (start_ok) begin
            cnt_d = '0;
        end

        if (accept && !trailer) begin
            ccff_head_d = in_data[BYTE_W-1];
            rest_d      = in_data[BYTE_W-2:0];
            bit_d       = '0;
        end

        if (state_q == SHIFT) begin
            cnt_d  = cnt_inc;
            bit_d  = bit_q + BIT_IDX_W'(1);
            rest_d = {rest_q[BYTE_W-3:0], 1'b0};
            // Head holds the last shifted bit once the byte (or chain) ends;
            // any unshifted low bits of a partial final byte are dropped
            if (!byte_end) begin
                ccff_head_d = rest_q[BYTE_W-2];
            end
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready      <= 1'b0;
            ccff_head     <= 1'b0;
            prog_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cnt_q         <= '0;
            bit_q         <= '0;
            rest_q        <= '0;
        end else begin
            in_ready      <= in_ready_d;
            ccff_head     <= ccff_head_d;
            prog_shift_en <= prog_shift_en_d;
            busy          <= busy_d;
            done          <= done_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            rest_q        <= rest_d;
        end
    end

`ifdef CFG_CRC_EN
    logic [BYTE_W-1:0] crc_val;

    // CRC sees exactly the bits presented to the chain
    cfg_crc8_serial u_crc (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (prog_shift_en),
        .din   (ccff_head),
        .crc   (crc_val)
    );

    // Trailer compare; result held through DONE until the next start
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            crc_err <= 1'b0;
        end else if (accept && trailer) begin
            crc_err <= (in_data != crc_val);
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_fpga_cfg_chain_loader
// Three loaders (CHAIN_LEN 16, 12, 8) share clock and reset. Expected chain
// bits are queued per instance when bytes are offered and popped whenever
// the instance asserts prog_shift_en. Honours CFG_CRC_EN when defined.
// ---------------------------------------------------------------------------
module tb_fpga_cfg_chain_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start_s;
    logic [2:0] valid_s;
    logic [7:0] data_s [3];
    logic [2:0] rdy, head, pse, busy, done, cerr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int shifts     [3];
    int last_shift [3];
    int xfer_cyc   [3];
    int chain_len  [3] = '{16, 12, 8};
    logic [7:0] mcrc [3];
    bit q0[$];
    bit q1[$];
    bit q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpga_cfg_chain_loader #(.CHAIN_LEN(16)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .in_data(data_s[0]),
        .in_valid(valid_s[0]), .in_ready(rdy[0]), .ccff_head(head[0]),
        .prog_shift_en(pse[0]), .busy(busy[0]), .done(done[0]), .crc_err(cerr[0]));

    fpga_cfg_chain_loader #(.CHAIN_LEN(12)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .in_data(data_s[1]),
        .in_valid(valid_s[1]), .in_ready(rdy[1]), .ccff_head(head[1]),
        .prog_shift_en(pse[1]), .busy(busy[1]), .done(done[1]), .crc_err(cerr[1]));

    fpga_cfg_chain_loader #(.CHAIN_LEN(8)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .in_data(data_s[2]),
        .in_valid(valid_s[2]), .in_ready(rdy[2]), .ccff_head(head[2]),
        .prog_shift_en(pse[2]), .busy(busy[2]), .done(done[2]), .crc_err(cerr[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_push(input int d, input bit b);
        case (d)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
        mcrc[d] = crc_step(mcrc[d], b);
    endtask

    task automatic q_pop(input int d, output bit b);
        case (d)
            0:       b = q0.pop_front();
            1:       b = q1.pop_front();
            default: b = q2.pop_front();
        endcase
    endtask

    // Scoreboard: every shift cycle must consume one queued expected bit
    always @(negedge clk) begin
        bit e;
        for (int d = 0; d < 3; d++) begin
            if (pse[d] === 1'b1) begin
                shifts[d]++;
                last_shift[d] = cyc;
                check($sformatf("dut%0d shift_expected", d), 32'(q_size(d) != 0), 32'd1);
                if (q_size(d) != 0) begin
                    q_pop(d, e);
                    check($sformatf("dut%0d ccff_head", d), 32'(head[d]), 32'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int d);
        start_s[d] = 1'b1;
        mcrc[d]    = 8'h00;
        shifts[d]  = 0;
        tick();
        start_s[d] = 1'b0;
        check($sformatf("dut%0d after start rdy/busy/done", d),
              {29'd0, rdy[d], busy[d], done[d]}, 32'b110);
`ifdef CFG_CRC_EN
        check($sformatf("dut%0d crc_err cleared by start", d), 32'(cerr[d]), 32'd0);
`endif
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input int nbits);
        int waited;
        waited = 0;
        for (int i = 0; i < nbits; i++) q_push(d, b[7-i]);
        data_s[d]  = b;
        valid_s[d] = 1'b1;
        while (rdy[d] !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check($sformatf("dut%0d handshake ready", d), 32'(rdy[d] === 1'b1), 32'd1);
        xfer_cyc[d] = cyc;
        tick();
        valid_s[d] = 1'b0;
        data_s[d]  = 8'($urandom);
    endtask

    task automatic finish_load(input int d, input logic bad);
        int   waited;
        int   ref_cyc;
        logic exp_err;
        waited  = 0;
        ref_cyc = 0;
        exp_err = 1'b0;
`ifdef CFG_CRC_EN
        send_byte(d, mcrc[d] ^ {7'd0, bad}, 0);
        ref_cyc = xfer_cyc[d];
        exp_err = bad;
`endif
        while (done[d] !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
`ifndef CFG_CRC_EN
        ref_cyc = last_shift[d];
`endif
        check($sformatf("dut%0d done reached", d), 32'(done[d] === 1'b1), 32'd1);
        check($sformatf("dut%0d done latency", d), 32'(cyc), 32'(ref_cyc + 1));
        check($sformatf("dut%0d DONE rdy/busy/pse", d), {29'd0, rdy[d], busy[d], pse[d]}, 32'd0);
        check($sformatf("dut%0d shift count", d), 32'(shifts[d]), 32'(chain_len[d]));
        check($sformatf("dut%0d queue drained", d), 32'(q_size(d)), 32'd0);
        check($sformatf("dut%0d crc_err", d), 32'(cerr[d]), 32'(exp_err));
        tick();
        check($sformatf("dut%0d done held", d), 32'(done[d]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start_s = '0;
        valid_s = '0;
        for (int d = 0; d < 3; d++) begin
            data_s[d]     = 8'h00;
            shifts[d]     = 0;
            last_shift[d] = 0;
            xfer_cyc[d]   = 0;
            mcrc[d]       = 8'h00;
        end
        repeat (3) tick();
        for (int d = 0; d < 3; d++)
            check($sformatf("dut%0d reset outputs", d),
                  {26'd0, rdy[d], head[d], pse[d], busy[d], done[d], cerr[d]}, 32'd0);
        reset = 1'b0;
        tick();
        check("dut0 idle without start", {29'd0, rdy[0], busy[0], pse[0]}, 32'd0);

        // Two full bytes into a 16-bit chain
        do_start(0);
        send_byte(0, 8'hA5, 8);
        send_byte(0, 8'h3C, 8);
        finish_load(0, 1'b0);

        // 12-bit chain: partial final byte, only 1011 of 0xB7 is shifted
        do_start(1);
        send_byte(1, 8'hFF, 8);
        send_byte(1, 8'hB7, 4);
        finish_load(1, 1'b0);
        check("dut1 head holds last bit", 32'(head[1]), 32'd1);

        // Reload from DONE, then stall in LOAD for 20 cycles
        do_start(0);
        for (int i = 0; i < 20; i++) begin
            check("dut0 stall rdy/pse/busy", {29'd0, rdy[0], pse[0], busy[0]}, 32'b101);
            tick();
        end
        send_byte(0, 8'h5A, 8);
        // start during SHIFT must be ignored
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        check("dut0 busy after start in SHIFT", {30'd0, busy[0], done[0]}, 32'b10);
        send_byte(0, 8'hC3, 8);
        finish_load(0, 1'b0);

        // in_valid in DONE consumes nothing
        data_s[0]  = 8'hFF;
        valid_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dut0 DONE ignores valid", {29'd0, done[0], rdy[0], busy[0]}, 32'b100);
        end
        valid_s[0] = 1'b0;

        // Reset during the 5th shift of the 2nd byte
        do_start(0);
        send_byte(0, 8'hAA, 8);
        send_byte(0, 8'h5D, 5);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("dut0 mid-load reset outputs",
              {26'd0, rdy[0], head[0], pse[0], busy[0], done[0], cerr[0]}, 32'd0);
        check("dut0 bits shifted before reset", 32'(shifts[0]), 32'd13);
        check("dut0 queue after reset", 32'(q_size(0)), 32'd0);
        tick();
        check("dut0 stays idle after reset", {30'd0, busy[0], rdy[0]}, 32'd0);
        do_start(0);
        send_byte(0, 8'h00, 8);
        send_byte(0, 8'h00, 8);
        finish_load(0, 1'b0);

        // 8-bit chain with byte 0x01: good trailer, then corrupted trailer
        do_start(2);
        send_byte(2, 8'h01, 8);
        finish_load(2, 1'b0);
        do_start(2);
        send_byte(2, 8'h01, 8);
        finish_load(2, 1'b1);
        do_start(2);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
